alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Consumer end of the 4-bit ALU control code: executes add/sub/and/or/nor/slt on two operands.
//  Multi-cycle, chunk-serial datapath: processes CHUNK_W bits per cycle, carry held in a register.
//  Valid/ready handshake on both sides; sits between decode/issue and writeback in the multi-cycle core.
//  Flags illegal control codes rather than silently producing garbage.
// PARAMETERS
//  DATA_W   32  operand/result width
//  CHUNK_W   8  bits processed per BUSY cycle; DATA_W % CHUNK_W == 0 required (elaboration error otherwise)
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       asynchronous, active-low reset
//  in_valid_i   in   1       operation request valid
//  in_ready_o   out  1       unit can accept (high only in IDLE)
//  alu_ctrl_i   in   4       0000 add, 0001 sub, 0010 and, 0011 or, 0100 nor, 0101 slt; all others illegal
//  src1_i       in   DATA_W  operand A
//  src2_i       in   DATA_W  operand B
//  out_valid_o  out  1       result valid (DONE state)
//  out_ready_i  in   1       downstream accepts result
//  result_o     out  DATA_W  result, registered
//  zero_o       out  1       result_o == 0 (legal ops only)
//  overflow_o   out  1       signed overflow, add/sub only; 0 for all other ops
//  illegal_o    out  1       alu_ctrl was not a legal code
// BEHAVIOUR
//  - Reset: state=IDLE; result_o=0, zero_o=0, overflow_o=0, illegal_o=0, out_valid_o=0; in_ready_o=1.
//  - States: IDLE, BUSY, DONE. in_ready_o = (state==IDLE); out_valid_o = (state==DONE).
//  - IDLE: on in_valid_i: latch A, B, code; clear result reg and chunk counter cnt=0;
//    carry = 1 for sub/slt else 0. Legal code -> BUSY; illegal -> DONE with result_o=0,
//    zero_o=0, overflow_o=0, illegal_o=1.
//  - BUSY: each cycle operates on bits [cnt*CHUNK_W +: CHUNK_W]; B inverted for sub/slt;
//    add/sub/slt use chunk sum + registered carry; and/or/nor bitwise. Chunk written into result reg.
//    cnt==N-1 (N=DATA_W/CHUNK_W) -> DONE; otherwise cnt++.
//  - Finalise on the last BUSY cycle: ovf = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]);
//    slt: result_o = {DATA_W-1 zeros, sum[msb]^ovf}, overflow_o=0; add/sub: overflow_o=ovf;
//    zero_o = (final result_o == 0). illegal_o=0.
//  - Latency: accept edge at cycle 0 -> out_valid_o high from cycle N+1 (N=4 -> 5 cycles).
//    Illegal: out_valid_o high from cycle 1.
//  - DONE: all outputs held stable while out_ready_i=0. On out_ready_i=1 -> IDLE.
//    A new request is never accepted in the same cycle the result is taken; throughput 1 op per N+2 cycles.
//  - in_valid_i / operand changes outside IDLE are ignored. Operands are latched only at acceptance.
//  - CHUNK_W==DATA_W is legal: one BUSY cycle.
//  - Wrap-around: add/sub wrap modulo 2^DATA_W; the final carry-out is discarded.
//  - Reset mid-operation: immediate return to IDLE and reset values. The partial result is lost.
// STRUCTURE
//  - Shared include alu_defs.vh: localparams ALU_ADD..ALU_SLT (4-bit codes), ALU_ILLEGAL=4'b1111,
//    state encodings S_IDLE/S_BUSY/S_DONE. The ALU control decoder uses the same file.
//  - One sub-module: alu_chunk_slice (combinational, CHUNK_W wide).
//    Inputs: a, b, cin, op. Outputs: y, cout, msb sum.
//  - The top level holds the FSM, chunk counter, operand/result registers and finalise logic.
// TESTING (DATA_W=32, CHUNK_W=8)
//  - add 0x0000_00FF + 0x0000_0001 -> result 0x0000_0100, zero=0, ovf=0, out_valid 5 cycles after accept.
//  - sub 0x8000_0000 - 0x0000_0001 -> result 0x7FFF_FFFF, overflow=1; sub 5-5 -> result 0, zero=1.
//  - slt 0xFFFF_FFFF(-1) vs 1 -> result 1; slt 0x7FFF_FFFF vs 0x8000_0000 -> result 0, overflow_o=0.
//  - nor 0xF0F0_F0F0, 0x0F0F_0000 -> 0x0000_0F0F; code 4'b0111 -> illegal=1, result 0, valid after 1 cycle.
//  - Backpressure: out_ready_i low 10 cycles in DONE -> outputs stable, in_ready_o=0, new in_valid ignored.
//  - rst_i low during BUSY cycle 2 -> in_ready_o=1, out_valid_o=0 immediately. A following add completes correctly.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU control codes, FSM state encoding and code-classification helpers
// for the chunk-serial execute unit and the ALU control decoder.
package alu_exec_unit_pkg;

   localparam logic [3:0] ALU_ADD     = 4'b0000;
   localparam logic [3:0] ALU_SUB     = 4'b0001;
   localparam logic [3:0] ALU_AND     = 4'b0010;
   localparam logic [3:0] ALU_OR      = 4'b0011;
   localparam logic [3:0] ALU_NOR     = 4'b0100;
   localparam logic [3:0] ALU_SLT     = 4'b0101;
   localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic is_legal(input logic [3:0] code);
      return (code == ALU_ADD) || (code == ALU_SUB) || (code == ALU_AND) ||
             (code == ALU_OR)  || (code == ALU_NOR) || (code == ALU_SLT);
   endfunction

   // sub and slt both compute A + ~B + 1
   function automatic logic uses_sub(input logic [3:0] code);
      return (code == ALU_SUB) || (code == ALU_SLT);
   endfunction

endpackage

// File: rtl/alu_exec_unit_chunk_slice.sv
// Combinational CHUNK_W-wide ALU slice: one chunk of add/sub/slt (with carry)
// or bitwise and/or/nor per BUSY cycle.
module alu_chunk_slice
   import alu_exec_unit_pkg::*;
#(
   parameter int CHUNK_W = 8
) (
   input  logic [CHUNK_W-1:0] a_i,
   input  logic [CHUNK_W-1:0] b_i,
   input  logic               cin_i,
   input  logic [3:0]         op_i,
   output logic [CHUNK_W-1:0] y_o,
   output logic               cout_o,
   output logic               sum_msb_o
);

   logic [CHUNK_W-1:0] b_eff;
   logic [CHUNK_W:0]   sum;

   always_comb begin
      b_eff = uses_sub(op_i) ? ~b_i : b_i;
      sum   = {1'b0, a_i} + {1'b0, b_eff} + {{CHUNK_W{1'b0}}, cin_i};
      case (op_i)
         ALU_ADD, ALU_SUB, ALU_SLT: y_o = sum[CHUNK_W-1:0];
         ALU_AND:                   y_o = a_i & b_i;
         ALU_OR:                    y_o = a_i | b_i;
         ALU_NOR:                   y_o = ~(a_i | b_i);
         default:                   y_o = '0;
      endcase
      cout_o    = sum[CHUNK_W];
      sum_msb_o = sum[CHUNK_W-1];
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle chunk-serial ALU execute unit with valid/ready on both sides.
// Operands shift right one chunk per BUSY cycle; result chunks shift in from the top.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int CHUNK_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [3:0]        alu_ctrl_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o,
   output logic              overflow_o,
   output logic              illegal_o
);

   localparam int N     = DATA_W / CHUNK_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   generate
      if (DATA_W % CHUNK_W != 0) begin : g_bad_chunk
         $error("alu_exec_unit: DATA_W must be a multiple of CHUNK_W");
      end
   endgenerate

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [3:0]          op_q, op_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                carry_q, carry_d;
   logic                zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;

   logic [CHUNK_W-1:0]  y;
   logic                cout, sum_msb;
   logic                ovf, b_msb_eff;
   logic [DATA_W-1:0]   res_shift;

   alu_chunk_slice #(.CHUNK_W(CHUNK_W)) u_slice (
      .a_i       (a_q[CHUNK_W-1:0]),
      .b_i       (b_q[CHUNK_W-1:0]),
      .cin_i     (carry_q),
      .op_i      (op_q),
      .y_o       (y),
      .cout_o    (cout),
      .sum_msb_o (sum_msb)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      res_d     = res_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      ill_d     = ill_q;
      // On the last chunk the low bits of a_q/b_q hold the operand MSBs
      b_msb_eff = b_q[CHUNK_W-1] ^ uses_sub(op_q);
      ovf       = (a_q[CHUNK_W-1] == b_msb_eff) && (sum_msb != a_q[CHUNK_W-1]);
      res_shift = res_q >> CHUNK_W;
      res_shift[DATA_W-1 -: CHUNK_W] = y;

      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               a_d     = src1_i;
               b_d     = src2_i;
               op_d    = alu_ctrl_i;
               cnt_d   = '0;
               carry_d = uses_sub(alu_ctrl_i);
               res_d   = '0;
               zero_d  = 1'b0;
               ovf_d   = 1'b0;
               if (is_legal(alu_ctrl_i)) begin
                  ill_d   = 1'b0;
                  state_d = S_BUSY;
               end else begin
                  ill_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_BUSY: begin
            a_d     = a_q >> CHUNK_W;
            b_d     = b_q >> CHUNK_W;
            carry_d = cout;
            res_d   = res_shift;
            if (cnt_q == LAST) begin
               if (op_q == ALU_SLT) begin
                  res_d = {{(DATA_W-1){1'b0}}, sum_msb ^ ovf};
               end
               ovf_d   = ((op_q == ALU_ADD) || (op_q == ALU_SUB)) && ovf;
               zero_d  = (res_d == '0);
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         ill_q   <= ill_d;
      end
   end

   assign in_ready_o  = (state_q == S_IDLE);
   assign out_valid_o = (state_q == S_DONE);
   assign result_o    = res_q;
   assign zero_o      = zero_q;
   assign overflow_o  = ovf_q;
   assign illegal_o   = ill_q;

endmodule
